// File: rtl/press_classifier.sv
// press_classifier: classifies a debounced button level into short, long and double press pulses
module press_classifier #(
    parameter int unsigned long_count = 500,
    parameter int unsigned gap_count  = 250,
    parameter int unsigned width      = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic in_i,
    input  logic valid_i,
    output logic short_press_o,
    output logic long_press_o,
    output logic double_press_o,
    output logic busy_o
);

    typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HOLD} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             busy_q;

    localparam logic [width-1:0] LongLast = width'(long_count - 1);
    localparam logic [width-1:0] GapLast  = width'(gap_count - 1);

    // next state, tick counter and pulse requests; a level change always beats a coincident tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        if (!valid_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_i) begin
                        state_d = PRESS1;
                        cnt_d   = '0;
                    end
                end
                PRESS1: begin
                    if (!in_i) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else if (enable_i) begin
                        if (cnt_q == LongLast) begin
                            state_d = HOLD;
                            long_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + width'(1);
                        end
                    end
                end
                GAP: begin
                    if (in_i) begin
                        state_d = PRESS2;
                        cnt_d   = '0;
                    end else if (enable_i) begin
                        if (cnt_q == GapLast) begin
                            state_d = IDLE;
                            short_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + width'(1);
                        end
                    end
                end
                PRESS2: begin
                    if (!in_i) begin
                        state_d = IDLE;
                        dbl_d   = 1'b1;
                    end
                end
                HOLD: begin
                    if (!in_i) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // state, counter and registered outputs; busy tracks the state being entered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign short_press_o  = short_q;
    assign long_press_o   = long_q;
    assign double_press_o = dbl_q;
    assign busy_o         = busy_q;

endmodule
